// File: rtl/mlp_layer_sequencer_if.sv
// Controller-side bundle of the MLP layer sequencer: start/count in, PE and weight-memory strobes out,
// held out_valid/out_ready completion. cycle_count exists only under MLP_SEQ_CYCLE_COUNT_EN.
interface mlp_layer_sequencer_if #(
  parameter int ADDR_WIDTH = 5
) ();
  logic                  start;
  logic [ADDR_WIDTH-1:0] num_inputs;
  logic                  busy;
  logic                  pe_clear;
  logic                  weight_load;
  logic [ADDR_WIDTH-1:0] weight_address;
  logic [ADDR_WIDTH-1:0] input_index;
  logic                  mac_en;
  logic                  out_valid;
  logic                  out_ready;
  logic                  error;
`ifdef MLP_SEQ_CYCLE_COUNT_EN
  logic [15:0]           cycle_count;
`endif

  modport master (
`ifdef MLP_SEQ_CYCLE_COUNT_EN
    output cycle_count,
`endif
    input  start, num_inputs, out_ready,
    output busy, pe_clear, weight_load, weight_address, input_index,
    output mac_en, out_valid, error
  );

  modport slave (
`ifdef MLP_SEQ_CYCLE_COUNT_EN
    input  cycle_count,
`endif
    output start, num_inputs, out_ready,
    input  busy, pe_clear, weight_load, weight_address, input_index,
    input  mac_en, out_valid, error
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Layer-pass FSM: clear, stream N weight rows, drain PE pipeline; out_valid at E(N+2+PE_LATENCY), held until out_ready.
// Optional busy-cycle counter under MLP_SEQ_CYCLE_COUNT_EN.
module mlp_layer_sequencer #(
  parameter int INPUT_NODES = 24,
  parameter int ADDR_WIDTH  = 5,
  parameter int PE_LATENCY  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  mlp_layer_sequencer_if.master     bus
);

  localparam int DRAIN_W = $clog2(PE_LATENCY + 2);
  localparam logic [ADDR_WIDTH-1:0] MAX_N      = ADDR_WIDTH'(INPUT_NODES);
  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(PE_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] n_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DRAIN_W-1:0]    drain_q;
  logic                  busy_q;
  logic                  pe_clear_q;
  logic                  weight_load_q;
  logic                  mac_en_q;
  logic                  out_valid_q;
  logic                  error_q;

  logic num_ok;
  logic accept;
  logic last_row;

  assign num_ok   = (bus.num_inputs != '0) && (bus.num_inputs <= MAX_N);
  assign accept   = (state_q == S_IDLE) && bus.start && num_ok;
  assign last_row = (addr_q == (n_q - ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      addr_q        <= '0;
      drain_q       <= '0;
      busy_q        <= 1'b0;
      pe_clear_q    <= 1'b0;
      weight_load_q <= 1'b0;
      mac_en_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      pe_clear_q <= 1'b0;
      error_q    <= 1'b0;
      // Weight memory has one cycle of read latency, so the MAC follows the load by one cycle.
      mac_en_q   <= weight_load_q;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            n_q        <= bus.num_inputs;
            state_q    <= S_CLEAR;
            busy_q     <= 1'b1;
            pe_clear_q <= 1'b1;
          end else if (bus.start) begin
            error_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          state_q       <= S_STREAM;
          weight_load_q <= 1'b1;
          addr_q        <= '0;
        end
        S_STREAM: begin
          if (last_row) begin
            weight_load_q <= 1'b0;
            addr_q        <= '0;
            drain_q       <= '0;
            state_q       <= S_DRAIN;
          end else begin
            addr_q <= addr_q + ONE;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.pe_clear       = pe_clear_q;
  assign bus.weight_load    = weight_load_q;
  assign bus.weight_address = addr_q;
  assign bus.input_index    = addr_q;
  assign bus.mac_en         = mac_en_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.error          = error_q;

`ifdef MLP_SEQ_CYCLE_COUNT_EN
  logic [15:0] cycle_count_q;
  logic [15:0] cycle_count_d;

  // The accept edge counts as the first busy cycle, so a pass ending at E(k) reports k+1.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (accept) begin
      cycle_count_d = 16'd1;
    end else if (busy_q && (cycle_count_q != 16'hFFFF)) begin
      cycle_count_d = cycle_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count_q <= 16'd0;
    end else begin
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Randomized bench for mlp_layer_sequencer: a timestamp model of each pass feeds queues that a negedge monitor drains.
module tb_mlp_layer_sequencer;
  localparam int IN = 24;
  localparam int AW = 5;
  localparam int PL = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mlp_layer_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  mlp_layer_sequencer #(
    .INPUT_NODES(IN),
    .ADDR_WIDTH (AW),
    .PE_LATENCY (PL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected event timestamps (edge index after which the output is seen high).
  int q_clr[$];
  int q_err[$];
  int q_mac[$];
  int q_ov[$];
  int q_wl_c[$];
  int q_wl_a[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flush_all();
    q_clr.delete(); q_err.delete(); q_mac.delete();
    q_ov.delete();  q_wl_c.delete(); q_wl_a.delete();
  endtask

  // Monitor: every strobe seen must match the head of its expectation queue.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.pe_clear) begin
      if (q_clr.size() == 0) chk("pe_clear_unexpected", 1, 0);
      else chk("pe_clear_cycle", cyc, q_clr.pop_front());
    end
    if (bus.error) begin
      if (q_err.size() == 0) chk("error_unexpected", 1, 0);
      else chk("error_cycle", cyc, q_err.pop_front());
    end
    if (bus.mac_en) begin
      if (q_mac.size() == 0) chk("mac_en_unexpected", 1, 0);
      else chk("mac_en_cycle", cyc, q_mac.pop_front());
    end
    if (bus.weight_load) begin
      if (q_wl_c.size() == 0) chk("weight_load_unexpected", 1, 0);
      else begin
        int a;
        a = q_wl_a.pop_front();
        chk("weight_load_cycle", cyc, q_wl_c.pop_front());
        chk("weight_address", 32'(bus.weight_address), a);
        chk("input_index", 32'(bus.input_index), a);
      end
    end else begin
      chk("address_idle_zero", 32'(bus.weight_address), 0);
    end
    if (bus.out_valid && !ov_prev) begin
      if (q_ov.size() == 0) chk("out_valid_unexpected", 1, 0);
      else chk("out_valid_rise_cycle", cyc, q_ov.pop_front());
    end
    ov_prev = bus.out_valid;
  end

  // Issue a start; push the spec-derived timeline of the pass when the count is legal.
  task automatic start_pass(input int n, input bit repulse, output int acc);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.num_inputs = AW'(n);
    acc = cyc + 1;
    if (n >= 1 && n <= IN) begin
      q_clr.push_back(acc);
      for (int i = 0; i < n; i++) begin
        q_wl_c.push_back(acc + 1 + i);
        q_wl_a.push_back(i);
        q_mac.push_back(acc + 2 + i);
      end
      q_ov.push_back(acc + n + 2 + PL);
    end else begin
      q_err.push_back(acc);
    end
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.num_inputs = AW'($urandom_range(0, 31));
    if (!(n >= 1 && n <= IN)) begin
      @(negedge clk);
      chk("busy_after_illegal", bus.busy, 0);
    end else if (repulse) begin
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.num_inputs = AW'($urandom_range(1, IN));
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic finish_pass(input int acc, input int delay, input bit start_with_ready);
    int t;
    int hs;
    t = 0;
    while (!bus.out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      chk("out_valid_held", bus.out_valid, 1);
      chk("busy_in_done", bus.busy, 1);
    end
    @(posedge clk); #1;
    bus.out_ready  = 1'b1;
    bus.start      = start_with_ready;
    bus.num_inputs = AW'(5);
    @(posedge clk); #1;
    hs = cyc;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    @(negedge clk);
    chk("busy_after_handshake", bus.busy, 0);
    chk("out_valid_after_handshake", bus.out_valid, 0);
`ifdef MLP_SEQ_CYCLE_COUNT_EN
    chk("cycle_count", 32'(bus.cycle_count), hs - acc + 1);
`endif
    @(negedge clk);
    chk("start_not_queued", bus.busy, 0);
`ifdef MLP_SEQ_CYCLE_COUNT_EN
    chk("cycle_count_hold", 32'(bus.cycle_count), hs - acc + 1);
`endif
  endtask

  // Reset k edges after the accept edge; everything must drop before the next clock.
  task automatic abort_pass(input int acc, input int k);
    while (cyc < acc + k) @(posedge clk);
    #1;
    reset = 1'b1;
    flush_all();
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_pe_clear", bus.pe_clear, 0);
    chk("rst_weight_load", bus.weight_load, 0);
    chk("rst_mac_en", bus.mac_en, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_address", 32'(bus.weight_address), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int acc;
    int n;
    int r;
    bus.start      = 1'b0;
    bus.num_inputs = '0;
    bus.out_ready  = 1'b0;

    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_pe_clear", bus.pe_clear, 0);
    chk("reset_weight_load", bus.weight_load, 0);
    chk("reset_mac_en", bus.mac_en, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_error", bus.error, 0);
    chk("reset_index", 32'(bus.input_index), 0);
`ifdef MLP_SEQ_CYCLE_COUNT_EN
    chk("reset_cycle_count", 32'(bus.cycle_count), 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed passes from the test plan.
    start_pass(24, 1'b0, acc);
    finish_pass(acc, 5, 1'b0);
    start_pass(0, 1'b0, acc);
    start_pass(25, 1'b0, acc);
    start_pass(3, 1'b1, acc);
    finish_pass(acc, 0, 1'b1);
    start_pass(24, 1'b0, acc);
    abort_pass(acc, 10);
    start_pass(5, 1'b0, acc);
    finish_pass(acc, 0, 1'b0);
    start_pass(1, 1'b1, acc);
    finish_pass(acc, 2, 1'b0);

    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(0, 31);
      r = $urandom_range(0, 9);
      if (n == 0 || n > IN) begin
        start_pass(n, 1'b0, acc);
      end else if (r == 0) begin
        start_pass(n, 1'b0, acc);
        abort_pass(acc, $urandom_range(2, n + 4));
      end else begin
        start_pass(n, r[0], acc);
        finish_pass(acc, $urandom_range(0, 4), r[1]);
      end
    end

    repeat (4) @(negedge clk);
    chk("pending_pe_clear", q_clr.size(), 0);
    chk("pending_error", q_err.size(), 0);
    chk("pending_mac_en", q_mac.size(), 0);
    chk("pending_weight_load", q_wl_c.size(), 0);
    chk("pending_out_valid", q_ov.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
